// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the DDS phase increment.
// Optional SWEEP_HOLD_EN adds a hold input that freezes the dwell count and phase_inc.
module dds_sweep_ctrl #(
  parameter int unsigned PHASE_W = 30,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         sweep_mode,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_stop,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SWEEP_HOLD_EN
  input  logic               hold,
`endif
  output logic [PHASE_W-1:0] phase_inc,
  output logic               busy,
  output logic               sweep_sync,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e             state_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [PHASE_W-1:0] start_q;
  logic [PHASE_W-1:0] stop_q;
  logic [PHASE_W-1:0] step_q;
  logic [1:0]         mode_q;
  logic               degen_q;

  logic [PHASE_W:0] up_sum;
  logic [PHASE_W:0] dn_diff;
  logic             up_clamp;
  logic             dn_clamp;
  logic             freeze;

  // Extra MSB catches carry out of the top / borrow below zero.
  assign up_sum   = {1'b0, phase_inc} + {1'b0, step_q};
  assign dn_diff  = {1'b0, phase_inc} - {1'b0, step_q};
  assign up_clamp = up_sum[PHASE_W] || (up_sum[PHASE_W-1:0] >= stop_q);
  assign dn_clamp = dn_diff[PHASE_W] || (dn_diff[PHASE_W-1:0] <= start_q);

`ifdef SWEEP_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dwell_q    <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      mode_q     <= '0;
      degen_q    <= 1'b0;
      phase_inc  <= '0;
      busy       <= 1'b0;
      sweep_sync <= 1'b0;
      done       <= 1'b0;
    end else begin
      sweep_sync <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              start_q    <= f_start;
              stop_q     <= f_stop;
              step_q     <= f_step;
              dwell_q    <= dwell;
              mode_q     <= sweep_mode;
              degen_q    <= (f_stop <= f_start) || (f_step == '0);
              cnt_q      <= dwell;
              phase_inc  <= f_start;
              busy       <= 1'b1;
              sweep_sync <= 1'b1;
              state_q    <= StUp;
            end
          end
          default: begin
            if (!freeze) begin
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - DWELL_W'(1);
              end else begin
                cnt_q <= dwell_q;
                if (degen_q) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end else if (state_q == StDown || (phase_inc == stop_q && mode_q == 2'b10)) begin
                  // Reaching f_start re-enters UP directly so that point is held only once.
                  if (dn_clamp) begin
                    phase_inc  <= start_q;
                    sweep_sync <= 1'b1;
                    state_q    <= StUp;
                  end else begin
                    phase_inc <= dn_diff[PHASE_W-1:0];
                    state_q   <= StDown;
                  end
                end else if (phase_inc == stop_q) begin
                  if (mode_q == 2'b01) begin
                    phase_inc  <= start_q;
                    sweep_sync <= 1'b1;
                  end else begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                  end
                end else begin
                  phase_inc <= up_clamp ? stop_q : up_sum[PHASE_W-1:0];
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table vectors, random sweeps, reset and hold sequences.
module tb_dds_sweep_ctrl;
  localparam int PW = 30;
  localparam int DW = 16;
  localparam longint TOP = 64'd1073741824;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [PW-1:0] fs;
  logic [PW-1:0] fe;
  logic [PW-1:0] fst;
  logic [DW-1:0] dw;
  logic [PW-1:0] phase_inc;
  logic          busy;
  logic          sweep_sync;
  logic          done;
`ifdef SWEEP_HOLD_EN
  logic          hold;
`endif

  dds_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .sweep_mode(mode),
    .f_start   (fs),
    .f_stop    (fe),
    .f_step    (fst),
    .dwell     (dw),
`ifdef SWEEP_HOLD_EN
    .hold      (hold),
`endif
    .phase_inc (phase_inc),
    .busy      (busy),
    .sweep_sync(sweep_sync),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint p;
    logic   b;
    logic   s;
    logic   d;
  } cyc_t;

  typedef struct {
    longint a;
    longint e;
    longint st;
    int     dwl;
    int     md;
    int     maxc;
    int     abort_at;
    bit     with_start;
  } vec_t;

  cyc_t tr[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic void push(longint p, logic b, logic s, logic d);
    cyc_t c;
    c.p = p; c.b = b; c.s = s; c.d = d;
    tr.push_back(c);
  endfunction

  // Expected per-cycle outputs from sweep rules: list of points, each held dwell+1 cycles.
  function automatic bit build(longint a, longint e, longint st, int dwl, int md, int maxc);
    longint v;
    bit     down;
    tr.delete();
    if (e <= a || st == 0) begin
      for (int k = 0; k <= dwl; k++) push(a, 1'b1, k == 0, 1'b0);
      push(a, 1'b0, 1'b0, 1'b1);
      push(a, 1'b0, 1'b0, 1'b0);
      return 1'b1;
    end
    v = a;
    down = 1'b0;
    while (tr.size() < maxc) begin
      for (int k = 0; k <= dwl; k++) push(v, 1'b1, (k == 0) && (v == a), 1'b0);
      if (!down && v == e) begin
        if (md == 1) begin
          v = a;
          continue;
        end else if (md == 2) begin
          down = 1'b1;
        end else begin
          push(e, 1'b0, 1'b0, 1'b1);
          push(e, 1'b0, 1'b0, 1'b0);
          return 1'b1;
        end
      end
      if (!down) begin
        v = (v + st >= e) ? e : v + st;
      end else begin
        v = v - st;
        if (v <= a) begin
          v = a;
          down = 1'b0;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic check(string name, cyc_t x);
    logic [PW-1:0] ep;
    ep = x.p[PW-1:0];
    vectors++;
    if (phase_inc !== ep || busy !== x.b || sweep_sync !== x.s || done !== x.d) begin
      errors++;
      $display("FAIL %s: got phase_inc=%0d busy=%0b sync=%0b done=%0b, want %0d %0b %0b %0b",
               name, phase_inc, busy, sweep_sync, done, ep, x.b, x.s, x.d);
    end
  endtask

  // Starts and ends at posedge+1.
  task automatic run(vec_t v, int hold_at);
    bit   complete;
    int   ab;
    cyc_t c;
    complete = build(v.a, v.e, v.st, v.dwl, v.md, v.maxc);
    if (hold_at >= 0) begin
      c = tr[hold_at];
      c.s = 1'b0;
      for (int k = 0; k < 7; k++) tr.insert(hold_at + 1, c);
    end
    ab = v.abort_at;
    if (!complete && ab < 0) ab = tr.size() - 1;
    if (ab >= tr.size()) ab = tr.size() - 1;
    fs = v.a[PW-1:0]; fe = v.e[PW-1:0]; fst = v.st[PW-1:0];
    dw = DW'(v.dwl); mode = 2'(v.md);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fs = PW'($urandom); fe = PW'($urandom); fst = PW'($urandom);
    dw = DW'($urandom); mode = 2'($urandom);
    for (int i = 0; i < tr.size(); i++) begin
      check("sweep", tr[i]);
      if (i == ab) begin
        c = tr[i];
        c.b = 1'b0; c.s = 1'b0; c.d = 1'b0;
        abort = 1'b1;
        start = v.with_start;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort", c);
        @(posedge clk); #1;
        check("post_abort_idle", c);
        return;
      end
`ifdef SWEEP_HOLD_EN
      if (i == hold_at) hold = 1'b1;
      if (i == hold_at + 7) hold = 1'b0;
`endif
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[8];
  vec_t rv;
  cyc_t zc;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
    fs = '0; fe = '0; fst = '0; dw = '0;
`ifdef SWEEP_HOLD_EN
    hold = 1'b0;
`endif
    zc.p = 0; zc.b = 1'b0; zc.s = 1'b0; zc.d = 1'b0;
    #1;
    check("reset_state", zc);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", zc);

    tbl[0] = '{100, 140, 10, 2, 0, 200, -1, 1'b0};
    tbl[1] = '{TOP - 30, TOP - 5, 20, 1, 0, 200, -1, 1'b0};
    tbl[2] = '{0, 30, 10, 0, 2, 40, 19, 1'b0};
    tbl[3] = '{100, 200, 10, 1, 1, 100, 4, 1'b1};
    tbl[4] = '{80, 50, 7, 4, 1, 100, -1, 1'b0};
    tbl[5] = '{5, 5, 3, 0, 3, 100, -1, 1'b0};
    tbl[6] = '{10, 100, 0, 1, 2, 100, -1, 1'b0};
    tbl[7] = '{10, 25, 40, 1, 2, 30, 25, 1'b1};
    for (int t = 0; t < 8; t++) run(tbl[t], -1);

    for (int r = 0; r < 40; r++) begin
      rv.a = longint'($urandom_range(0, 200));
      rv.e = rv.a + longint'($urandom_range(0, 300)) - 40;
      if (rv.e < 0) rv.e = 0;
      rv.st = longint'($urandom_range(0, 60));
      if ($urandom_range(0, 3) == 0) begin
        rv.a = rv.a + TOP - 400;
        rv.e = rv.e + TOP - 400;
        if (rv.e > TOP - 1) rv.e = TOP - 1;
      end
      rv.dwl = $urandom_range(0, 3);
      rv.md = $urandom_range(0, 3);
      rv.maxc = 150;
      rv.abort_at = ($urandom_range(0, 2) == 0 || rv.md == 1 || rv.md == 2)
                    ? $urandom_range(0, 149) : -1;
      rv.with_start = 1'($urandom_range(0, 1));
      run(rv, -1);
    end

    // Asynchronous reset in the middle of a sweep.
    fs = 100; fe = 140; fst = 10; dw = 2; mode = 2'b01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("async_reset", zc);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_async_reset", zc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    zc.p = 100; zc.b = 1'b1; zc.s = 1'b1;
    check("restart_sync", zc);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    zc.b = 1'b0; zc.s = 1'b0;
    check("restart_abort", zc);

`ifdef SWEEP_HOLD_EN
    run('{100, 140, 10, 2, 0, 200, -1, 1'b0}, 4);
    run('{0, 30, 10, 0, 2, 40, 30, 1'b0}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the 30-bit phase increment input of the DDS waveform stage directly upstream of it. On a start pulse it steps the phase increment from a start value to a stop value in fixed linear steps. Each point is held for a programmable number of clocks. Sweeps can run once, repeat, or ping-pong. It provides sync and done strobes for scope triggering and host status.

Parameters:
PHASE_W, 30, width of phase_inc and the frequency operands (matches the DDS phase_inc port).
DWELL_W, 16, width of the dwell counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a sweep when idle.
abort  in  1  level/pulse; stops any sweep and returns to idle.
sweep_mode  in  2  00 single, 01 repeat, 10 triangle, 11 treated as single.
f_start  in  PHASE_W  first phase increment.
f_stop  in  PHASE_W  last phase increment.
f_step  in  PHASE_W  increment added or subtracted per point.
dwell  in  DWELL_W  clocks per point, minus one (0 = 1 clock).
phase_inc  out  PHASE_W  registered phase increment to the DDS.
busy  out  1  high while a sweep is active.
sweep_sync  out  1  one-cycle pulse each time phase_inc is loaded with f_start.
done  out  1  one-cycle pulse when a single sweep completes.

Behaviour:
- Reset is async on rst_n low. phase_inc=0, busy=0, sweep_sync=0, done=0, FSM=IDLE, dwell counter=0.
- FSM states: IDLE, UP, DOWN.
- Operand capture: f_start, f_stop, f_step, dwell and sweep_mode are latched on the accepted start edge. Input changes during a sweep have no effect.
- Start: start is accepted only in IDLE and ignored while busy. If start is accepted in cycle N, then in cycle N+1 phase_inc=f_start, busy=1, sweep_sync=1, and the FSM enters UP.
- Dwell: the counter loads the latched dwell value and counts down to 0. The point changes on the clock after the count reaches 0. Each point is therefore held exactly dwell+1 cycles.
- UP step: next = phase_inc + f_step, computed in PHASE_W+1 bits. If next >= f_stop or the carry is set, phase_inc=f_stop (clamped). Otherwise phase_inc=next.
- End of the f_stop dwell, by mode:
  - single: go to IDLE; busy falls and done=1 in the same cycle; phase_inc holds f_stop.
  - repeat: phase_inc=f_start, sweep_sync=1, stay in UP.
  - triangle: go to DOWN.
- DOWN step: next = phase_inc - f_step. If a borrow occurs or next <= f_start, phase_inc=f_start, sweep_sync=1, and the FSM enters UP after that point's dwell. The f_start point is held once, not twice.
- Degenerate case: if f_stop <= f_start or f_step == 0 at start, phase_inc=f_start is held for one dwell period in any mode. Then done=1 and the FSM returns to IDLE.
- Abort has priority over every other event, including a simultaneous start.
  - Next cycle: IDLE, busy=0, phase_inc holds its current value.
  - Neither done nor sweep_sync is asserted.
- Reset mid-sweep forces reset values immediately, with no done pulse.
- done and sweep_sync never assert in the same cycle, except in the degenerate case, where sweep_sync is on the first cycle and done on the last.

Optional Feature:
Macro SWEEP_HOLD_EN.
- Defined: adds input hold (1 bit). While hold=1 in UP or DOWN, the dwell counter and phase_inc freeze. abort and rst_n still act. Releasing hold resumes the count where it stopped.
- Not defined: the port is absent and the dwell counter always runs.

Test Plan:
1. Single sweep: f_start=100, f_stop=140, f_step=10, dwell=2, mode=00 -> phase_inc goes 100,110,120,130,140, each held 3 cycles; sweep_sync at the first 100; done one cycle after the last 140 cycle; busy high for 15 cycles.
2. Clamp and overflow: f_start=2^30-30, f_stop=2^30-5, f_step=20 -> points are 2^30-30 then 2^30-10, then clamp to 2^30-5; no wrap to a small value.
3. Triangle: 0->30, step 10, dwell=0, mode=10 -> 0,10,20,30,20,10,0,10..., with sweep_sync on each 0 and done never asserted.
4. Repeat with abort: mode=01, abort asserted at the third point -> busy=0 next cycle, phase_inc frozen at the third value, no done; a start on the same cycle as abort is ignored.
5. Degenerate: f_stop=50, f_start=80, dwell=4 -> phase_inc=80 for 5 cycles, sweep_sync then done, return to IDLE.
6. Async reset mid-sweep: rst_n low between clock edges -> all outputs 0 immediately; a new start after release yields sweep_sync one cycle later. With SWEEP_HOLD_EN defined, hold=1 for 7 cycles extends the current point by exactly 7 cycles.
